// File: rtl/montpro_ctrl_if.sv
// Request/response handshake bundle between the point-arithmetic scheduler and montpro_ctrl.
// The scheduler uses the master modport and the controller uses the slave modport.
interface montpro_ctrl_if #(
  parameter int WID = 256
);
  logic           req_vld;
  logic           req_rdy;
  logic [WID-1:0] req_a;
  logic [WID-1:0] req_b;
  logic [WID-1:0] req_m;
  logic           rsp_vld;
  logic           rsp_rdy;
  logic [WID-1:0] rsp_r;
  logic           rsp_err;

  modport master (
    output req_vld, req_a, req_b, req_m, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_r, rsp_err
  );

  modport slave (
    input  req_vld, req_a, req_b, req_m, rsp_rdy,
    output req_rdy, rsp_vld, rsp_r, rsp_err
  );
endinterface

// File: rtl/montpro_ctrl.sv
// Sequencer for one bit-serial Montgomery multiplier: load, count WID shift pulses, final subtract of m.
// Optional watchdog on shift-pulse spacing is enabled by defining MONTPRO_CTRL_TIMEOUT_EN.
module montpro_ctrl #(
  parameter int WID = 256,
  parameter int TMO = 15
) (
  input  logic            clk,
  input  logic            rst,
  montpro_ctrl_if.slave   bus,
  output logic            busy,
  output logic [WID-1:0]  mp_a,
  output logic [WID-1:0]  mp_b,
  output logic [WID-1:0]  mp_m,
  output logic            mp_ldnew,
  input  logic            mp_shiften,
  input  logic [WID:0]    mp_r
);

  localparam int CW = $clog2(WID + 1);

  if (TMO < 1 || WID < 2) begin : g_cfg_err
    $error("montpro_ctrl: WID must be >= 2 and TMO >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_SUB,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WID-1:0] a_q, a_d;
  logic [WID-1:0] b_q, b_d;
  logic [WID-1:0] m_q, m_d;
  logic [WID-1:0] r_q, r_d;
  logic [WID:0]   sub_diff;

  assign sub_diff = mp_r - {1'b0, m_q};

`ifdef MONTPRO_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0]  wd_q, wd_d;
  logic           err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    r_d     = r_q;
`ifdef MONTPRO_CTRL_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_vld) begin
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          m_d     = bus.req_m;
`ifdef MONTPRO_CTRL_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
`ifdef MONTPRO_CTRL_TIMEOUT_EN
        wd_d    = '0;
`endif
        state_d = S_ITER;
      end
      S_ITER: begin
        if (mp_shiften) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WID - 1)) begin
            state_d = S_SUB;
          end
`ifdef MONTPRO_CTRL_TIMEOUT_EN
          wd_d = '0;
        end else if (wd_q == TW'(TMO - 1)) begin
          // Datapath stalled: abort with a zero result flagged as an error.
          r_d     = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + TW'(1);
`endif
        end
      end
      S_SUB: begin
        // montpro leaves r in [0, 2m); one conditional subtract finishes the reduction.
        if (mp_r >= {1'b0, m_q}) begin
          r_d = sub_diff[WID-1:0];
        end else begin
          r_d = mp_r[WID-1:0];
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.rsp_rdy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
`ifdef MONTPRO_CTRL_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      r_q     <= r_d;
`ifdef MONTPRO_CTRL_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.req_rdy = (state_q == S_IDLE);
  assign bus.rsp_vld = (state_q == S_DONE);
  assign bus.rsp_r   = r_q;
`ifdef MONTPRO_CTRL_TIMEOUT_EN
  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif
  assign busy        = (state_q != S_IDLE);
  assign mp_ldnew    = (state_q == S_LOAD);
  assign mp_a        = a_q;
  assign mp_b        = b_q;
  assign mp_m        = m_q;

endmodule

// File: tb/tb_montpro_ctrl.sv
// Bench for montpro_ctrl at WID=8 with a behavioural bit-serial montpro stand-in.
// Expected results come from a brute-force modular-inverse reference, not from the datapath model.
module tb_montpro_ctrl;

  localparam int WID = 8;
  localparam int TMO = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic           busy;
  logic [WID-1:0] mp_a, mp_b, mp_m;
  logic           mp_ldnew;
  logic           mp_shiften;
  logic [WID:0]   mp_r;

  montpro_ctrl_if #(.WID(WID)) bus ();

  montpro_ctrl #(.WID(WID), .TMO(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .mp_a       (mp_a),
    .mp_b       (mp_b),
    .mp_m       (mp_m),
    .mp_ldnew   (mp_ldnew),
    .mp_shiften (mp_shiften),
    .mp_r       (mp_r)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Stand-in controls
  bit rand_gaps   = 1'b0;
  bit force_en    = 1'b0;
  int force_val   = 0;
  int stall_after = WID;

  task automatic chk(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // x such that x * 2^WID == a*b (mod m)
  function automatic int ref_mont(input int a, input int b, input int m);
    for (int x = 0; x < m; x++) begin
      if (((x * (1 << WID)) % m) == ((a * b) % m)) return x;
    end
    return -1;
  endfunction

  function automatic int pick_gap();
    return rand_gaps ? int'($urandom_range(0, 4)) : 4;
  endfunction

  // Behavioural montpro: updates r on each consumed shift pulse, LSB of a first.
  initial begin : montpro_model
    bit       st_busy;
    int       st_bit, st_gap, st_b, st_m, t;
    logic [WID-1:0] st_a;
    st_busy = 1'b0; st_bit = 0; st_gap = 0; st_b = 0; st_m = 0; st_a = '0;
    mp_shiften = 1'b0;
    mp_r = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        st_busy = 1'b0;
        mp_shiften = 1'b0;
        mp_r = '0;
      end else begin
        if (mp_shiften) begin
          t = int'(mp_r) + (st_a[st_bit] ? st_b : 0);
          if (t % 2 == 1) t = t + st_m;
          mp_r = (WID+1)'(t / 2);
          st_bit++;
          if (st_bit == WID && force_en) mp_r = (WID+1)'(force_val);
          mp_shiften = 1'b0;
          if (st_bit == WID) st_busy = 1'b0;
          else st_gap = pick_gap();
        end
        if (mp_ldnew) begin
          st_busy = 1'b1;
          st_bit  = 0;
          st_a    = mp_a;
          st_b    = int'(mp_b);
          st_m    = int'(mp_m);
          mp_r    = '0;
          st_gap  = pick_gap();
        end else if (st_busy && st_bit < stall_after && !mp_shiften) begin
          if (st_gap == 0) mp_shiften = 1'b1;
          else st_gap--;
        end
      end
    end
  end

  // Present a request and return on the negedge after it was accepted (LOAD cycle).
  task automatic issue(input int a, input int b, input int m);
    int n;
    @(negedge clk);
    bus.req_a   = WID'(a);
    bus.req_b   = WID'(b);
    bus.req_m   = WID'(m);
    bus.req_vld = 1'b1;
    n = 0;
    while (!bus.req_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_rdy) chk("req_accept_timeout", 0, 1);
    @(negedge clk);
    bus.req_vld = 1'b0;
  endtask

  // Count load/shift pulses until the response, check it, optionally stall and press a new request.
  task automatic finish(input int exp_r, input int exp_err, input int rdy_dly, input bit press);
    int n, nld, nsh;
    n = 0; nld = 0; nsh = 0;
    while (!bus.rsp_vld && n < 2000) begin
      if (mp_ldnew) nld++;
      if (mp_shiften) nsh++;
      @(negedge clk);
      n++;
    end
    chk("rsp_vld_seen", bus.rsp_vld, 1);
    chk("rsp_r", bus.rsp_r, exp_r);
    chk("rsp_err", bus.rsp_err, exp_err);
    chk("ldnew_cycles", nld, 1);
    chk("shift_pulses", nsh, WID);
    if (press) begin
      bus.req_a = WID'(1); bus.req_b = WID'(1); bus.req_m = WID'(13);
      bus.req_vld = 1'b1;
    end
    for (int k = 0; k < rdy_dly; k++) begin
      @(negedge clk);
      chk("hold_vld", bus.rsp_vld, 1);
      chk("hold_r", bus.rsp_r, exp_r);
      chk("hold_req_rdy", bus.req_rdy, 0);
    end
    bus.rsp_rdy = 1'b1;
    @(negedge clk);
    bus.rsp_rdy = 1'b0;
    chk("rsp_vld_drop", bus.rsp_vld, 0);
    chk("req_rdy_back", bus.req_rdy, 1);
  endtask

  typedef struct {
    int a;
    int b;
    int m;
    bit frc;
    int fval;
    int exp_r;
  } vec_t;

  vec_t tbl[7];

  initial begin : main
    int n, nsh, m, a, b;
    bit busy_drop;

    tbl[0] = '{a: 5,  b: 7,  m: 13, frc: 1'b0, fval: 0,     exp_r: 1};
    tbl[1] = '{a: 12, b: 12, m: 13, frc: 1'b0, fval: 0,     exp_r: 3};
    tbl[2] = '{a: 1,  b: 1,  m: 13, frc: 1'b0, fval: 0,     exp_r: 3};
    tbl[3] = '{a: 0,  b: 9,  m: 13, frc: 1'b0, fval: 0,     exp_r: 0};
    tbl[4] = '{a: 5,  b: 7,  m: 13, frc: 1'b1, fval: 'h012, exp_r: 5};
    tbl[5] = '{a: 5,  b: 7,  m: 13, frc: 1'b1, fval: 'h00C, exp_r: 12};
    tbl[6] = '{a: 5,  b: 7,  m: 13, frc: 1'b1, fval: 'h00D, exp_r: 0};

    rst = 1'b1;
    bus.req_vld = 1'b0;
    bus.req_a = '0; bus.req_b = '0; bus.req_m = '0;
    bus.rsp_rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp_vld", bus.rsp_vld, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ldnew", mp_ldnew, 0);
    chk("rst_req_rdy", bus.req_rdy, 1);
    chk("rst_rsp_r", bus.rsp_r, 0);
    chk("rst_mp_a", mp_a, 0);
    chk("rst_mp_m", mp_m, 0);

    // Directed vectors, datapath pulsing every 5 cycles
    for (int i = 0; i < 7; i++) begin
      force_en  = tbl[i].frc;
      force_val = tbl[i].fval;
      issue(tbl[i].a, tbl[i].b, tbl[i].m);
      finish(tbl[i].exp_r, 0, i % 3, 1'b0);
    end
    force_en = 1'b0;

    // Backpressure for 10 cycles with a competing request held on the bus
    issue(5, 7, 13);
    finish(1, 0, 10, 1'b1);
    @(negedge clk);
    chk("bp_accept_busy", busy, 1);
    chk("bp_accept_mp_a", mp_a, 1);
    chk("bp_accept_ldnew", mp_ldnew, 1);
    bus.req_vld = 1'b0;
    finish(3, 0, 0, 1'b0);

    // Reset after three shift pulses
    issue(5, 7, 13);
    nsh = 0; n = 0;
    while (nsh < 3 && n < 200) begin
      if (mp_shiften) nsh++;
      if (nsh < 3) begin @(negedge clk); n++; end
    end
    chk("midrst_pulses", nsh, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp_vld", bus.rsp_vld, 0);
    chk("midrst_req_rdy", bus.req_rdy, 1);
    chk("midrst_ldnew", mp_ldnew, 0);
    rst = 1'b0;
    issue(5, 7, 13);
    finish(1, 0, 0, 1'b0);

    // Datapath stalls after two pulses
    stall_after = 2;
    issue(5, 7, 13);
    nsh = 0; n = 0;
    while (nsh < 2 && n < 200) begin
      if (mp_shiften) nsh++;
      if (nsh < 2) begin @(negedge clk); n++; end
    end
    chk("stall_pulses", nsh, 2);
    n = 0; busy_drop = 1'b0;
    while (!bus.rsp_vld && n < 100) begin
      @(negedge clk);
      n++;
      if (!busy) busy_drop = 1'b1;
    end
`ifdef MONTPRO_CTRL_TIMEOUT_EN
    chk("tmo_vld", bus.rsp_vld, 1);
    chk("tmo_err", bus.rsp_err, 1);
    chk("tmo_r", bus.rsp_r, 0);
    chk("tmo_cycles", n, TMO + 1);
    bus.rsp_rdy = 1'b1;
    @(negedge clk);
    bus.rsp_rdy = 1'b0;
    stall_after = WID;
    issue(12, 12, 13);
    chk("tmo_err_clear", bus.rsp_err, 0);
    finish(3, 0, 0, 1'b0);
`else
    chk("hang_vld", bus.rsp_vld, 0);
    chk("hang_busy_drop", busy_drop, 0);
    chk("hang_busy", busy, 1);
    chk("hang_err", bus.rsp_err, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    stall_after = WID;
`endif

    // Random operands, random pulse spacing and random response backpressure
    rand_gaps = 1'b1;
    for (int i = 0; i < 30; i++) begin
      m = int'($urandom_range(1, 127)) * 2 + 1;
      a = int'($urandom_range(0, m - 1));
      b = int'($urandom_range(0, m - 1));
      issue(a, b, m);
      finish(ref_mont(a, b, m), 0, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
